// File: rtl/frame_disassembly.sv
// frame_disassembly: receive side of the MHP byte-stream link.
// Parses dst/src/size/{dir,type}/payload/scs from a byte stream. It recomputes
// the shifted-sum checksum and presents good frames with a one-cycle strobe.
// Optional build macro RX_ADDR_FILTER_EN: when defined, frames whose dst is
// neither MY_ADDR nor broadcast (16'hFFFF) are silently dropped.
module frame_disassembly #(
  parameter int          MAX_PAYLOAD = 42,
  parameter int          TIMEOUT     = 15,
  parameter logic [15:0] MY_ADDR     = 16'h0001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               i_rdata,
  input  logic                     i_rvalid,
  output logic [15:0]              o_dst,
  output logic [15:0]              o_src,
  output logic [15:0]              o_size,
  output logic                     o_dir,
  output logic [6:0]               o_type,
  output logic [MAX_PAYLOAD*8-1:0] o_payload,
  output logic [5:0]               o_payload_size,
  output logic                     o_frame_valid,
  output logic                     o_err,
  output logic [1:0]               o_err_code,
  output logic                     o_busy
);

  localparam int PW = $clog2(MAX_PAYLOAD);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, SCS_HI, SCS_LO, DROP} state_t;

  state_t                      state, state_nxt;
  logic [7:0]                  idx;        // wire-format index of the next byte
  logic [15:0]                 sum;        // running shifted-sum checksum
  logic [CW-1:0]               idle_cnt;   // consecutive idle cycles inside a frame
  logic [15:0]                 dst_sh, src_sh, size_sh;
  logic [7:0]                  dt_sh, scs_hi;
  logic [MAX_PAYLOAD-1:0][7:0] pay_sh;
  logic                        set_ok, set_err, addr_ok, timeout_hit;
  logic [1:0]                  code_nxt;
  logic [15:0]                 sh_byte, size_new;
  logic [7:0]                  pofs;

  assign sh_byte     = 16'(i_rdata) << idx[1:0];
  assign size_new    = {i_rdata, size_sh[7:0]};
  assign pofs        = idx - 8'd7;
  assign timeout_hit = !i_rvalid && (idle_cnt == CW'(TIMEOUT));
  assign o_busy      = (state != IDLE);

`ifdef RX_ADDR_FILTER_EN
  assign addr_ok = (dst_sh == MY_ADDR) || (dst_sh == 16'hFFFF);
`else
  assign addr_ok = 1'b1;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and result strobes
  always_comb begin
    state_nxt = state;
    set_ok    = 1'b0;
    set_err   = 1'b0;
    code_nxt  = 2'd0;
    case (state)
      IDLE: if (i_rvalid) state_nxt = HDR;
      HDR: begin
        if (i_rvalid) begin
          if (idx == 8'd5 && size_new > 16'(MAX_PAYLOAD)) begin
            set_err = 1'b1; code_nxt = 2'd2; state_nxt = DROP;
          end else if (idx == 8'd6) begin
            state_nxt = (size_sh != 16'd0) ? PAYLOAD : SCS_HI;
          end
        end else if (timeout_hit) begin
          set_err = 1'b1; code_nxt = 2'd3; state_nxt = IDLE;
        end
      end
      PAYLOAD: begin
        if (i_rvalid) begin
          if (idx == size_sh[7:0] + 8'd6) state_nxt = SCS_HI;
        end else if (timeout_hit) begin
          set_err = 1'b1; code_nxt = 2'd3; state_nxt = IDLE;
        end
      end
      SCS_HI: begin
        if (i_rvalid) state_nxt = SCS_LO;
        else if (timeout_hit) begin
          set_err = 1'b1; code_nxt = 2'd3; state_nxt = IDLE;
        end
      end
      SCS_LO: begin
        if (i_rvalid) begin
          state_nxt = IDLE;
          if ({scs_hi, i_rdata} != sum) begin
            set_err = 1'b1; code_nxt = 2'd1;
          end else if (addr_ok) begin
            set_ok = 1'b1;
          end
        end else if (timeout_hit) begin
          set_err = 1'b1; code_nxt = 2'd3; state_nxt = IDLE;
        end
      end
      DROP: if (!i_rvalid && idle_cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // byte capture, checksum accumulation, idle counting and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      sum            <= '0;
      idle_cnt       <= '0;
      dst_sh         <= '0;
      src_sh         <= '0;
      size_sh        <= '0;
      dt_sh          <= '0;
      scs_hi         <= '0;
      pay_sh         <= '0;
      o_dst          <= '0;
      o_src          <= '0;
      o_size         <= '0;
      o_dir          <= 1'b0;
      o_type         <= '0;
      o_payload      <= '0;
      o_payload_size <= '0;
      o_frame_valid  <= 1'b0;
      o_err          <= 1'b0;
      o_err_code     <= '0;
    end else begin
      o_frame_valid <= set_ok;
      o_err         <= set_err;
      if (set_err) o_err_code <= code_nxt;
      if (set_ok) begin
        o_dst          <= dst_sh;
        o_src          <= src_sh;
        o_size         <= size_sh;
        o_dir          <= dt_sh[7];
        o_type         <= dt_sh[6:0];
        o_payload      <= pay_sh;
        o_payload_size <= size_sh[5:0];
      end

      if (i_rvalid || state_nxt == IDLE) idle_cnt <= '0;
      else                               idle_cnt <= idle_cnt + CW'(1);

      if (i_rvalid) begin
        case (state)
          IDLE: begin
            dst_sh <= {8'h00, i_rdata};
            sum    <= 16'(i_rdata);
            idx    <= 8'd1;
            pay_sh <= '0;
          end
          HDR: begin
            sum <= sum + sh_byte;
            idx <= idx + 8'd1;
            case (idx)
              8'd1: dst_sh[15:8]  <= i_rdata;
              8'd2: src_sh[7:0]   <= i_rdata;
              8'd3: src_sh[15:8]  <= i_rdata;
              8'd4: size_sh[7:0]  <= i_rdata;
              8'd5: size_sh[15:8] <= i_rdata;
              8'd6: dt_sh         <= i_rdata;
              default: ;
            endcase
          end
          PAYLOAD: begin
            sum                  <= sum + sh_byte;
            idx                  <= idx + 8'd1;
            pay_sh[pofs[PW-1:0]] <= i_rdata;
          end
          SCS_HI: scs_hi <= i_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_disassembly.sv
// Directed self-checking bench for frame_disassembly.
module tb_frame_disassembly;
  localparam int MP = 42;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    i_rdata;
  logic          i_rvalid;
  logic [15:0]   o_dst, o_src, o_size;
  logic          o_dir;
  logic [6:0]    o_type;
  logic [MP*8-1:0] o_payload;
  logic [5:0]    o_payload_size;
  logic          o_frame_valid, o_err, o_busy;
  logic [1:0]    o_err_code;

  int total = 0;
  int bad   = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  logic [15:0] dst_log[$];
  logic [7:0]  f1[$];

  frame_disassembly #(.MAX_PAYLOAD(MP), .TIMEOUT(15), .MY_ADDR(16'h0001)) dut (
    .clk(clk), .rst(rst), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .o_dst(o_dst), .o_src(o_src), .o_size(o_size), .o_dir(o_dir),
    .o_type(o_type), .o_payload(o_payload), .o_payload_size(o_payload_size),
    .o_frame_valid(o_frame_valid), .o_err(o_err), .o_err_code(o_err_code),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // strobe recorder
  always @(negedge clk) begin
    if (o_frame_valid) begin
      ok_cnt++;
      dst_log.push_back(o_dst);
    end
    if (o_err) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] q[$], input int gap);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      i_rvalid = 1'b1;
      i_rdata  = q[i];
      if (i != q.size() - 1)
        repeat (gap) begin @(negedge clk); i_rvalid = 1'b0; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); i_rvalid = 1'b0; end
  endtask

  // transmitter-side frame builder: payload byte k = base + k
  task automatic build(input logic [15:0] dst, input logic [15:0] src,
                       input logic [7:0] dt, input int n, input logic [7:0] base,
                       output logic [7:0] q[$]);
    logic [15:0] s;
    q = {};
    q.push_back(dst[7:0]); q.push_back(dst[15:8]);
    q.push_back(src[7:0]); q.push_back(src[15:8]);
    q.push_back(8'(n));    q.push_back(8'(n >> 8));
    q.push_back(dt);
    for (int k = 0; k < n; k++) q.push_back(base + 8'(k));
    s = 16'h0;
    for (int i = 0; i < q.size(); i++) s = s + ({8'h00, q[i]} << (i % 4));
    q.push_back(s[15:8]);
    q.push_back(s[7:0]);
  endtask

  task automatic test_reset;
    rst = 1'b1; i_rvalid = 1'b0; i_rdata = 8'h00;
    repeat (2) @(negedge clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    total++; if (o_frame_valid !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", o_frame_valid, o_err); end
    total++; if (o_dst !== 16'h0 || o_err_code !== 2'd0 || o_payload !== '0) begin bad++; $display("FAIL reset_fields dst=%h code=%0d", o_dst, o_err_code); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_good;
    send(f1, 0);
    idle(1);
    total++; if (o_frame_valid !== 1'b1 || o_err !== 1'b0) begin bad++; $display("FAIL good_strobe got v=%b e=%b exp v=1 e=0", o_frame_valid, o_err); end
    total++; if (o_dst !== 16'h1234) begin bad++; $display("FAIL good_dst got=%h exp=1234", o_dst); end
    total++; if (o_src !== 16'hABCD) begin bad++; $display("FAIL good_src got=%h exp=abcd", o_src); end
    total++; if (o_size !== 16'd2 || o_payload_size !== 6'd2) begin bad++; $display("FAIL good_size got=%0d/%0d exp=2/2", o_size, o_payload_size); end
    total++; if (o_dir !== 1'b1 || o_type !== 7'h05) begin bad++; $display("FAIL good_dirtype got=%b/%h exp=1/05", o_dir, o_type); end
    total++; if (o_payload[15:0] !== 16'h55AA) begin bad++; $display("FAIL good_payload got=%h exp=55aa", o_payload[15:0]); end
    total++; if (o_payload[MP*8-1:16] !== '0) begin bad++; $display("FAIL good_payload_upper not zero"); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL good_busy got=%b exp=0", o_busy); end
    idle(1);
    total++; if (o_frame_valid !== 1'b0) begin bad++; $display("FAIL good_one_cycle got=%b exp=0", o_frame_valid); end
  endtask

  task automatic test_bad_scs;
    logic [7:0] q[$];
    q = f1;
    q[10] = 8'h9E;
    send(q, 0);
    idle(1);
    total++; if (o_err !== 1'b1 || o_frame_valid !== 1'b0) begin bad++; $display("FAIL scs_strobe got e=%b v=%b exp e=1 v=0", o_err, o_frame_valid); end
    total++; if (o_err_code !== 2'd1) begin bad++; $display("FAIL scs_code got=%0d exp=1", o_err_code); end
    total++; if (o_dst !== 16'h1234 || o_payload[15:0] !== 16'h55AA) begin bad++; $display("FAIL scs_fields_held dst=%h pay=%h", o_dst, o_payload[15:0]); end
    idle(1);
  endtask

  task automatic test_len_err;
    logic [7:0] h[$];
    logic [7:0] r[$];
    int ok0;
    h = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h2B, 8'h00};
    r = '{8'hAA, 8'h55, 8'h10, 8'h9F};
    ok0 = ok_cnt;
    send(h, 0);
    @(negedge clk);
    total++; if (o_err !== 1'b1 || o_err_code !== 2'd2) begin bad++; $display("FAIL len_err got e=%b code=%0d exp e=1 code=2", o_err, o_err_code); end
    i_rvalid = 1'b1; i_rdata = 8'h85;
    send(r, 0);
    idle(1);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL len_drop_busy got=%b exp=1", o_busy); end
    idle(3);
    total++; if (o_busy !== 1'b0 || ok_cnt != ok0) begin bad++; $display("FAIL len_drop_exit busy=%b strobes=%0d exp busy=0 strobes=0", o_busy, ok_cnt - ok0); end
    send(f1, 0);
    idle(1);
    total++; if (o_frame_valid !== 1'b1 || o_dst !== 16'h1234) begin bad++; $display("FAIL len_recover got v=%b dst=%h exp v=1 dst=1234", o_frame_valid, o_dst); end
    idle(1);
  endtask

  task automatic test_gaps_timeout;
    logic [7:0] p[$];
    int ok0;
    int er0;
    ok0 = ok_cnt;
    send(f1, 3);
    idle(3);
    total++; if (ok_cnt != ok0 + 1) begin bad++; $display("FAIL gap_strobes got=%0d exp=1", ok_cnt - ok0); end
    total++; if (o_src !== 16'hABCD || o_payload[15:0] !== 16'h55AA || o_payload_size !== 6'd2) begin bad++; $display("FAIL gap_fields src=%h pay=%h n=%0d", o_src, o_payload[15:0], o_payload_size); end
    total++; if (o_err_code !== 2'd2) begin bad++; $display("FAIL gap_code_held got=%0d exp=2", o_err_code); end
    p = f1[0:7];
    er0 = err_cnt;
    send(p, 0);
    idle(16);
    total++; if (o_err !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL timeout_early got e=%b busy=%b exp e=0 busy=1", o_err, o_busy); end
    idle(1);
    total++; if (o_err !== 1'b1 || o_err_code !== 2'd3 || o_busy !== 1'b0) begin bad++; $display("FAIL timeout got e=%b code=%0d busy=%b exp 1/3/0", o_err, o_err_code, o_busy); end
    idle(2);
    total++; if (err_cnt != er0 + 1) begin bad++; $display("FAIL timeout_count got=%0d exp=1", err_cnt - er0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b[$];
    int n0;
    build(16'hBEEF, 16'h0102, 8'h13, 42, 8'h01, b);
    n0 = dst_log.size();
    send(f1, 0);
    send(b, 0);
    idle(3);
    total++; if (dst_log.size() != n0 + 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", dst_log.size() - n0); end
    else begin
      total++; if (dst_log[n0] !== 16'h1234 || dst_log[n0+1] !== 16'hBEEF) begin bad++; $display("FAIL b2b_dsts got=%h,%h exp=1234,beef", dst_log[n0], dst_log[n0+1]); end
    end
    total++; if (o_size !== 16'd42 || o_payload_size !== 6'd42) begin bad++; $display("FAIL b2b_size got=%0d/%0d exp=42/42", o_size, o_payload_size); end
    total++; if (o_dir !== 1'b0 || o_type !== 7'h13 || o_src !== 16'h0102) begin bad++; $display("FAIL b2b_hdr dir=%b type=%h src=%h", o_dir, o_type, o_src); end
    total++; if (o_payload[7:0] !== 8'h01 || o_payload[MP*8-1 -: 8] !== 8'h2A) begin bad++; $display("FAIL b2b_payload first=%h last=%h exp=01,2a", o_payload[7:0], o_payload[MP*8-1 -: 8]); end
  endtask

  task automatic test_filter_rst;
    logic [7:0] q[$];
    int ok0;
    int er0;
    int exp_ok;
    ok0 = ok_cnt;
    build(16'h0001, 16'h0002, 8'h01, 0, 8'h00, q); send(q, 0);
    build(16'hFFFF, 16'h0002, 8'h01, 0, 8'h00, q); send(q, 0);
    build(16'h1234, 16'h0002, 8'h01, 0, 8'h00, q); send(q, 0);
    idle(3);
`ifdef RX_ADDR_FILTER_EN
    exp_ok = 2;
`else
    exp_ok = 3;
`endif
    total++; if (ok_cnt - ok0 != exp_ok) begin bad++; $display("FAIL filter_count got=%0d exp=%0d", ok_cnt - ok0, exp_ok); end
    ok0 = ok_cnt;
    er0 = err_cnt;
    q = f1[0:3];
    send(q, 0);
    @(negedge clk);
    rst = 1'b1; i_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    total++; if (o_busy !== 1'b0 || o_dst !== 16'h0) begin bad++; $display("FAIL rst_mid busy=%b dst=%h exp 0/0000", o_busy, o_dst); end
    idle(20);
    total++; if (ok_cnt != ok0 || err_cnt != er0) begin bad++; $display("FAIL rst_mid_strobes ok=%0d err=%0d exp=0,0", ok_cnt - ok0, err_cnt - er0); end
  endtask

  initial begin
    f1 = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h02, 8'h00, 8'h85, 8'hAA, 8'h55, 8'h10, 8'h9F};
    test_reset();
    test_good();
    test_bad_scs();
    test_len_err();
    test_gaps_timeout();
    test_back_to_back();
    test_filter_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
